// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional result cache of the last completed operation, enabled by `define DIV_RESULT_CACHE_EN.
module div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       func3,
    input  logic             div_en,
    input  logic             div_flush,
    output logic [WIDTH-1:0] op1_div_op2,
    output logic [WIDTH-1:0] op1_div_op2_rem,
    output logic             div_valid,
    output logic             div_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] quo_q;   // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             start;
    logic             is_signed;
    logic             zero_div;
    logic             ovf;
    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last_step;
    logic             cache_hit;
    logic [WIDTH-1:0] hit_quo;
    logic [WIDTH-1:0] hit_rem;

    always_comb begin
        start     = (state == IDLE) && div_en && func3[2] && !div_flush;
        is_signed = ~func3[0];
        zero_div  = (op2 == '0);
        ovf       = is_signed && (op1 == MinNeg) && (op2 == '1);
        abs_op1   = op1;
        abs_op2   = op2;
        if (is_signed && op1[WIDTH-1]) abs_op1 = -op1;
        if (is_signed && op2[WIDTH-1]) abs_op2 = -op2;

        // Partial remainder stays below the divisor, so a non-negative trial fits in WIDTH bits.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo_fix   = neg_quo_q ? -quo_step : quo_step;
        rem_fix   = neg_rem_q ? -rem_step : rem_step;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

`ifdef DIV_RESULT_CACHE_EN
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic             uns_q;
    logic             cache_vld_q;
    logic [WIDTH-1:0] cache_op1_q;
    logic [WIDTH-1:0] cache_op2_q;
    logic             cache_uns_q;
    logic [WIDTH-1:0] cache_quo_q;
    logic [WIDTH-1:0] cache_rem_q;

    always_comb begin
        cache_hit = cache_vld_q && (cache_op1_q == op1) && (cache_op2_q == op2) &&
                    (cache_uns_q == func3[0]);
        hit_quo   = cache_quo_q;
        hit_rem   = cache_rem_q;
    end

    // Results are committed to the cache only when DONE is left without a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1_q       <= '0;
            op2_q       <= '0;
            uns_q       <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_op1_q <= '0;
            cache_op2_q <= '0;
            cache_uns_q <= 1'b0;
            cache_quo_q <= '0;
            cache_rem_q <= '0;
        end else begin
            if (start) begin
                op1_q <= op1;
                op2_q <= op2;
                uns_q <= func3[0];
            end
            if (state == DONE && !div_flush) begin
                cache_vld_q <= 1'b1;
                cache_op1_q <= op1_q;
                cache_op2_q <= op2_q;
                cache_uns_q <= uns_q;
                cache_quo_q <= op1_div_op2;
                cache_rem_q <= op1_div_op2_rem;
            end
        end
    end
`else
    always_comb begin
        cache_hit = 1'b0;
        hit_quo   = '0;
        hit_rem   = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            quo_q           <= '0;
            rem_q           <= '0;
            dvs_q           <= '0;
            cnt_q           <= '0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            op1_div_op2     <= '0;
            op1_div_op2_rem <= '0;
            div_valid       <= 1'b0;
            div_busy        <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q     <= abs_op1;
                        dvs_q     <= abs_op2;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                        neg_rem_q <= is_signed && op1[WIDTH-1];
                        div_busy  <= 1'b1;
                        if (cache_hit) begin
                            state           <= DONE;
                            div_valid       <= 1'b1;
                            op1_div_op2     <= hit_quo;
                            op1_div_op2_rem <= hit_rem;
                        end else if (zero_div) begin
                            state           <= DONE;
                            div_valid       <= 1'b1;
                            op1_div_op2     <= '1;
                            op1_div_op2_rem <= op1;
                        end else if (ovf) begin
                            state           <= DONE;
                            div_valid       <= 1'b1;
                            op1_div_op2     <= op1;
                            op1_div_op2_rem <= '0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_flush) begin
                        state    <= IDLE;
                        div_busy <= 1'b0;
                    end else begin
                        quo_q <= quo_step;
                        rem_q <= rem_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            state           <= DONE;
                            div_valid       <= 1'b1;
                            op1_div_op2     <= quo_fix;
                            op1_div_op2_rem <= rem_fix;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (WIDTH=32): vector table, corner sequences, random vs. model.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  func3;
    logic        div_en;
    logic        div_flush;
    logic [31:0] op1_div_op2;
    logic [31:0] op1_div_op2_rem;
    logic        div_valid;
    logic        div_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] last_q = 0;
    logic [31:0] last_r = 0;
    logic        c_vld  = 0;
    logic [31:0] c_a    = 0;
    logic [31:0] c_b    = 0;
    logic        c_u    = 0;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .op1             (op1),
        .op2             (op2),
        .func3           (func3),
        .div_en          (div_en),
        .div_flush       (div_flush),
        .op1_div_op2     (op1_div_op2),
        .op1_div_op2_rem (op1_div_op2_rem),
        .div_valid       (div_valid),
        .div_busy        (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic plus the two special cases and a cache lookup.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa  = a;
        sb  = b;
        lat = 33;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (f[0]) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0; lat = 1;
        end else begin
            q = sa / sb; r = sa % sb;
        end
`ifdef DIV_RESULT_CACHE_EN
        if (c_vld && c_a == a && c_b == b && c_u == f[0]) lat = 1;
`endif
    endfunction

    // Caller must be away from the rising edge. poke >= 0 retries div_en with other operands mid-op.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] eq, input logic [31:0] er,
                         input int elat, input int poke);
        int   k;
        int   idle_busy;
        logic got;
        op1 = a; op2 = b; func3 = f; div_en = 1'b1;
        @(posedge clk);
        #1 div_en = 1'b0;
        k = 0; got = 1'b0; idle_busy = 0;
        while (!got && k < 80) begin
            @(negedge clk);
            k++;
            if (div_valid) got = 1'b1;
            if (!div_busy) idle_busy++;
            if (k == poke) begin
                op1 = ~a; op2 = 32'd1; func3 = 3'b101; div_en = 1'b1;
            end else begin
                div_en = 1'b0;
            end
        end
        div_en = 1'b0;
        chk({name, " valid_seen"}, 32'(got), 32'd1);
        chk({name, " latency"}, 32'(k), 32'(elat));
        chk({name, " quotient"}, op1_div_op2, eq);
        chk({name, " remainder"}, op1_div_op2_rem, er);
        chk({name, " busy_gaps"}, 32'(idle_busy), 32'd0);
        @(negedge clk);
        chk({name, " busy_after"}, 32'(div_busy), 32'd0);
        chk({name, " valid_pulse"}, 32'(div_valid), 32'd0);
        last_q = eq; last_r = er;
        c_vld = 1'b1; c_a = a; c_b = b; c_u = f[0];
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] eq;
        logic [31:0] er;
        int          elat;
        int          sel;

        vecs[0] = '{"divu_100_7",   32'd100,        32'd7,          3'b101, 32'd14,         32'd2,          33};
        vecs[1] = '{"div_m7_2",     32'hFFFF_FFF9,  32'd2,          3'b100, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{"divu_5_0",     32'd5,          32'd0,          3'b101, 32'hFFFF_FFFF,  32'd5,          1};
        vecs[3] = '{"div_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  3'b100, 32'h8000_0000,  32'd0,          1};
        vecs[4] = '{"rem_7_m2",     32'd7,          32'hFFFF_FFFE,  3'b110, 32'hFFFF_FFFD,  32'd1,          33};
        vecs[5] = '{"remu_max_16",  32'hFFFF_FFFF,  32'h10,         3'b111, 32'h0FFF_FFFF,  32'hF,          33};
        vecs[6] = '{"divu_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  3'b101, 32'd0,          32'h8000_0000,  33};
        vecs[7] = '{"div_m100_m7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  3'b100, 32'd14,         32'hFFFF_FFFE,  33};
        vecs[8] = '{"div_0_0",      32'd0,          32'd0,          3'b100, 32'hFFFF_FFFF,  32'd0,          1};
        vecs[9] = '{"divu_3_5",     32'd3,          32'd5,          3'b101, 32'd0,          32'd3,          33};

        rst = 1'b0; op1 = 0; op2 = 0; func3 = 0; div_en = 0; div_flush = 0;
        repeat (3) @(negedge clk);
        chk("reset quotient", op1_div_op2, 32'd0);
        chk("reset remainder", op1_div_op2_rem, 32'd0);
        chk("reset valid", 32'(div_valid), 32'd0);
        chk("reset busy", 32'(div_busy), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].q, vecs[i].r,
                  vecs[i].lat, -1);
        end

        // Same operands, REM instead of DIV: a cache hit when the cache is built in.
        @(negedge clk);
        model(32'd100, 32'd7, 3'b101, eq, er, elat);
        do_op("cache_first", 32'd100, 32'd7, 3'b101, 32'd14, 32'd2, elat, -1);
        @(negedge clk);
`ifdef DIV_RESULT_CACHE_EN
        do_op("cache_second", 32'd100, 32'd7, 3'b111, 32'd14, 32'd2, 1, -1);
`else
        do_op("cache_second", 32'd100, 32'd7, 3'b111, 32'd14, 32'd2, 33, -1);
`endif

        @(negedge clk);
        do_op("en_while_busy", 32'd1000, 32'd10, 3'b101, 32'd100, 32'd0, 33, 5);

        // Flush in CALC at N+10: idle at N+11, no valid, outputs unchanged.
        begin
            int vcount;
            vcount = 0;
            @(negedge clk);
            op1 = 32'h1234_5678; op2 = 32'd3; func3 = 3'b101; div_en = 1'b1;
            @(posedge clk);
            #1 div_en = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (div_valid) vcount++;
            end
            div_flush = 1'b1;
            @(posedge clk);
            #1 div_flush = 1'b0;
            @(negedge clk);
            chk("flush busy_n11", 32'(div_busy), 32'd0);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (div_valid) vcount++;
            end
            chk("flush no_valid", 32'(vcount), 32'd0);
            chk("flush quotient_held", op1_div_op2, last_q);
            chk("flush remainder_held", op1_div_op2_rem, last_r);
        end
        model(32'h1234_5678, 32'd3, 3'b101, eq, er, elat);
        do_op("after_flush", 32'h1234_5678, 32'd3, 3'b101, eq, er, elat, -1);

        @(negedge clk);
        op1 = 32'd9; op2 = 32'd3; func3 = 3'b101; div_en = 1'b1; div_flush = 1'b1;
        @(posedge clk);
        #1 div_en = 1'b0; div_flush = 1'b0;
        @(negedge clk);
        chk("flush_wins_idle busy", 32'(div_busy), 32'd0);
        chk("flush_wins_idle quotient", op1_div_op2, last_q);

        op1 = 32'd9; op2 = 32'd3; func3 = 3'b011; div_en = 1'b1;
        @(posedge clk);
        #1 div_en = 1'b0;
        @(negedge clk);
        chk("bad_func3 busy", 32'(div_busy), 32'd0);
        chk("bad_func3 valid", 32'(div_valid), 32'd0);

        // Reset at N+5 clears outputs at once; start at first edge after release.
        @(negedge clk);
        op1 = 32'h0000_FFFF; op2 = 32'd3; func3 = 3'b101; div_en = 1'b1;
        @(posedge clk);
        #1 div_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst quotient", op1_div_op2, 32'd0);
        chk("midrst remainder", op1_div_op2_rem, 32'd0);
        chk("midrst valid", 32'(div_valid), 32'd0);
        chk("midrst busy", 32'(div_busy), 32'd0);
        #1 rst = 1'b1;
        c_vld = 1'b0; last_q = 0; last_r = 0;
        do_op("rst_restart", 32'd100, 32'd7, 3'b101, 32'd14, 32'd2, 33, -1);

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) b = 32'hFFFF_FFFF;
            if (sel == 2) a = 32'h8000_0000;
            if (sel == 3) a = 32'h0000_0064;
            f = 3'(4 + $urandom_range(0, 3));
            model(a, b, f, eq, er, elat);
            @(negedge clk);
            do_op("random", a, b, f, eq, er, elat, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
